// File: rtl/id_ex_stage_if.sv
// Decode/execute bundle shared by the ID/EX pipeline register and its neighbours.
// The master drives the decode side and observes EX; the slave is the pipeline register.
interface id_ex_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);
  logic              id_regdst;
  logic              id_j;
  logic              id_beq;
  logic              id_bneq;
  logic              id_memread;
  logic              id_memtoreg;
  logic              id_memwrite;
  logic              id_regwrite;
  logic [1:0]        id_alu_src;
  logic [2:0]        id_alu_op;
  logic [DATA_W-1:0] id_pc4;
  logic [DATA_W-1:0] id_rs_data;
  logic [DATA_W-1:0] id_rt_data;
  logic [15:0]       id_imm;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic [REG_AW-1:0] id_rd;

  logic              stall;

  logic              ex_regdst;
  logic              ex_j;
  logic              ex_beq;
  logic              ex_bneq;
  logic              ex_memread;
  logic              ex_memtoreg;
  logic              ex_memwrite;
  logic              ex_regwrite;
  logic [1:0]        ex_alu_src;
  logic [2:0]        ex_alu_op;
  logic [DATA_W-1:0] ex_pc4;
  logic [DATA_W-1:0] ex_rs_data;
  logic [DATA_W-1:0] ex_rt_data;
  logic [DATA_W-1:0] ex_imm_ext;
  logic [REG_AW-1:0] ex_rs;
  logic [REG_AW-1:0] ex_rt;
  logic [REG_AW-1:0] ex_dst;
  logic              ex_valid;
  logic [CNT_W-1:0]  stall_count;

  modport master (
    output id_regdst, id_j, id_beq, id_bneq, id_memread, id_memtoreg, id_memwrite,
           id_regwrite, id_alu_src, id_alu_op, id_pc4, id_rs_data, id_rt_data,
           id_imm, id_rs, id_rt, id_rd,
    input  stall, ex_regdst, ex_j, ex_beq, ex_bneq, ex_memread, ex_memtoreg,
           ex_memwrite, ex_regwrite, ex_alu_src, ex_alu_op, ex_pc4, ex_rs_data,
           ex_rt_data, ex_imm_ext, ex_rs, ex_rt, ex_dst, ex_valid, stall_count
  );

  modport slave (
    input  id_regdst, id_j, id_beq, id_bneq, id_memread, id_memtoreg, id_memwrite,
           id_regwrite, id_alu_src, id_alu_op, id_pc4, id_rs_data, id_rt_data,
           id_imm, id_rs, id_rt, id_rd,
    output stall, ex_regdst, ex_j, ex_beq, ex_bneq, ex_memread, ex_memtoreg,
           ex_memwrite, ex_regwrite, ex_alu_src, ex_alu_op, ex_pc4, ex_rs_data,
           ex_rt_data, ex_imm_ext, ex_rs, ex_rt, ex_dst, ex_valid, stall_count
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register of the 5-stage MIPS core: immediate extension,
// load-use hazard detection and bubble insertion for stalls and flushes.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input logic         clk,
  input logic         reset,
  input logic         flush,
  id_ex_stage_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // alu_src 00 still sign-extends so branch offsets reach EX correctly
  function automatic logic [DATA_W-1:0] extend_imm(input logic [1:0] src, input logic [15:0] imm);
    logic [DATA_W-1:0] ext;
    case (src)
      2'b00, 2'b01: ext = {{(DATA_W-16){imm[15]}}, imm};
      2'b10:        ext = {{(DATA_W-16){1'b0}}, imm};
      default:      ext = {DATA_W{1'b0}};
    endcase
    return ext;
  endfunction

  logic             hazard_s;
  logic             stall_s;
  logic             load_bubble_s;
  logic [CNT_W-1:0] cnt_r;

  // Load-use hazard: a valid load in EX whose non-zero target is read by ID
  always_comb begin
    hazard_s = bus.ex_memread & bus.ex_valid & (bus.ex_rt != {REG_AW{1'b0}}) &
               ((bus.ex_rt == bus.id_rs) | (bus.ex_rt == bus.id_rt));
    if (reset) begin
      stall_s = 1'b0;
    end else begin
      stall_s = hazard_s;
    end
    load_bubble_s = flush | stall_s;
  end

  assign bus.stall       = stall_s;
  assign bus.stall_count = cnt_r;

  // Pipeline register: reset or bubble clears every field, otherwise capture ID
  always_ff @(posedge clk) begin
    if (reset || load_bubble_s) begin
      bus.ex_regdst   <= 1'b0;
      bus.ex_j        <= 1'b0;
      bus.ex_beq      <= 1'b0;
      bus.ex_bneq     <= 1'b0;
      bus.ex_memread  <= 1'b0;
      bus.ex_memtoreg <= 1'b0;
      bus.ex_memwrite <= 1'b0;
      bus.ex_regwrite <= 1'b0;
      bus.ex_alu_src  <= 2'b00;
      bus.ex_alu_op   <= 3'b000;
      bus.ex_pc4      <= {DATA_W{1'b0}};
      bus.ex_rs_data  <= {DATA_W{1'b0}};
      bus.ex_rt_data  <= {DATA_W{1'b0}};
      bus.ex_imm_ext  <= {DATA_W{1'b0}};
      bus.ex_rs       <= {REG_AW{1'b0}};
      bus.ex_rt       <= {REG_AW{1'b0}};
      bus.ex_dst      <= {REG_AW{1'b0}};
      bus.ex_valid    <= 1'b0;
    end else begin
      bus.ex_regdst   <= bus.id_regdst;
      bus.ex_j        <= bus.id_j;
      bus.ex_beq      <= bus.id_beq;
      bus.ex_bneq     <= bus.id_bneq;
      bus.ex_memread  <= bus.id_memread;
      bus.ex_memtoreg <= bus.id_memtoreg;
      bus.ex_memwrite <= bus.id_memwrite;
      bus.ex_regwrite <= bus.id_regwrite;
      bus.ex_alu_src  <= bus.id_alu_src;
      bus.ex_alu_op   <= bus.id_alu_op;
      bus.ex_pc4      <= bus.id_pc4;
      bus.ex_rs_data  <= bus.id_rs_data;
      bus.ex_rt_data  <= bus.id_rt_data;
      bus.ex_imm_ext  <= extend_imm(bus.id_alu_src, bus.id_imm);
      bus.ex_rs       <= bus.id_rs;
      bus.ex_rt       <= bus.id_rt;
      bus.ex_dst      <= bus.id_regdst ? bus.id_rd : bus.id_rt;
      bus.ex_valid    <= 1'b1;
    end
  end

  // Saturating stall counter; flushed stall cycles are not counted
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (stall_s && !flush && (cnt_r != CNT_MAX)) begin
      cnt_r <= cnt_r + CNT_ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized self-checking bench for id_ex_stage against a behavioural model
// of the EX-stage contents, stall signal and stall counter.
module tb_id_ex_stage;

  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  typedef struct packed {
    logic        regdst, j, beq, bneq, memread, memtoreg, memwrite, regwrite;
    logic [1:0]  alu_src;
    logic [2:0]  alu_op;
    logic [31:0] pc4, rs_data, rt_data;
    logic [15:0] imm;
    logic [4:0]  rs, rt, rd;
  } instr_t;

  typedef struct packed {
    logic        valid;
    logic [7:0]  ctl;
    logic [1:0]  alu_src;
    logic [2:0]  alu_op;
    logic [31:0] pc4, rs_data, rt_data, imm_ext;
    logic [4:0]  rs, rt, dst;
  } ex_t;

  logic clk = 1'b0;
  logic reset;
  logic flush;

  id_ex_stage_if #(.DATA_W(32), .REG_AW(5), .CNT_W(CW)) bus ();

  id_ex_stage #(.DATA_W(32), .REG_AW(5), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .flush(flush), .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // model: what EX holds, and the stall counter as a plain integer
  instr_t m_ins;
  bit     m_valid;
  int     m_cnt;
  instr_t cur_ins;
  bit     cur_fl, cur_rst, exp_stall;

  function automatic ex_t model_view();
    ex_t v;
    int  simm;
    v = '0;
    if (m_valid) begin
      v.valid   = 1'b1;
      v.ctl     = {m_ins.regdst, m_ins.j, m_ins.beq, m_ins.bneq, m_ins.memread,
                   m_ins.memtoreg, m_ins.memwrite, m_ins.regwrite};
      v.alu_src = m_ins.alu_src;
      v.alu_op  = m_ins.alu_op;
      v.pc4     = m_ins.pc4;
      v.rs_data = m_ins.rs_data;
      v.rt_data = m_ins.rt_data;
      simm = int'(m_ins.imm);
      if (simm >= 32768) simm = simm - 65536;
      if (m_ins.alu_src == 2'd3)      v.imm_ext = 32'd0;
      else if (m_ins.alu_src == 2'd2) v.imm_ext = 32'(int'(m_ins.imm));
      else                            v.imm_ext = 32'(simm);
      v.rs  = m_ins.rs;
      v.rt  = m_ins.rt;
      v.dst = m_ins.regdst ? m_ins.rd : m_ins.rt;
    end
    return v;
  endfunction

  function automatic ex_t dut_view();
    ex_t v;
    v.valid   = bus.ex_valid;
    v.ctl     = {bus.ex_regdst, bus.ex_j, bus.ex_beq, bus.ex_bneq, bus.ex_memread,
                 bus.ex_memtoreg, bus.ex_memwrite, bus.ex_regwrite};
    v.alu_src = bus.ex_alu_src;
    v.alu_op  = bus.ex_alu_op;
    v.pc4     = bus.ex_pc4;
    v.rs_data = bus.ex_rs_data;
    v.rt_data = bus.ex_rt_data;
    v.imm_ext = bus.ex_imm_ext;
    v.rs      = bus.ex_rs;
    v.rt      = bus.ex_rt;
    v.dst     = bus.ex_dst;
    return v;
  endfunction

  function automatic instr_t rand_ins();
    instr_t i;
    i = '0;
    {i.regdst, i.j, i.beq, i.bneq} = 4'($urandom);
    {i.memread, i.memtoreg, i.memwrite, i.regwrite} = 4'($urandom);
    i.alu_src = 2'($urandom);
    i.alu_op  = 3'($urandom);
    i.pc4     = $urandom;
    i.rs_data = $urandom;
    i.rt_data = $urandom;
    i.imm     = 16'($urandom);
    i.rs      = 5'($urandom);
    i.rt      = 5'($urandom);
    i.rd      = 5'($urandom);
    return i;
  endfunction

  function automatic instr_t plain_ins();
    instr_t i;
    i = rand_ins();
    i.memread = 1'b0;
    return i;
  endfunction

  task automatic apply(input instr_t ins, input bit fl, input bit rst);
    bus.id_regdst   = ins.regdst;   bus.id_j        = ins.j;
    bus.id_beq      = ins.beq;      bus.id_bneq     = ins.bneq;
    bus.id_memread  = ins.memread;  bus.id_memtoreg = ins.memtoreg;
    bus.id_memwrite = ins.memwrite; bus.id_regwrite = ins.regwrite;
    bus.id_alu_src  = ins.alu_src;  bus.id_alu_op   = ins.alu_op;
    bus.id_pc4      = ins.pc4;      bus.id_rs_data  = ins.rs_data;
    bus.id_rt_data  = ins.rt_data;  bus.id_imm      = ins.imm;
    bus.id_rs       = ins.rs;       bus.id_rt       = ins.rt;
    bus.id_rd       = ins.rd;
    flush   = fl;
    reset   = rst;
    cur_ins = ins;
    cur_fl  = fl;
    cur_rst = rst;
    #1;
    exp_stall = !rst && m_valid && m_ins.memread && (m_ins.rt != 5'd0) &&
                ((m_ins.rt == ins.rs) || (m_ins.rt == ins.rt));
  endtask

  task automatic tick();
    @(posedge clk);
    if (cur_rst) begin
      m_ins = '0; m_valid = 1'b0; m_cnt = 0;
    end else if (cur_fl || exp_stall) begin
      if (!cur_fl) m_cnt = (m_cnt + 1 > CMAX) ? CMAX : m_cnt + 1;
      m_ins = '0; m_valid = 1'b0;
    end else begin
      m_ins = cur_ins; m_valid = 1'b1;
    end
    #1;
  endtask

  task automatic test_reset();
    apply(rand_ins(), 1'b0, 1'b1);
    tick();
    apply(rand_ins(), 1'b0, 1'b1);
    checks++;
    if (bus.stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", bus.stall); end
    tick();
    checks++;
    if (dut_view() !== ex_t'(0)) begin errors++; $display("FAIL reset_ex got %h exp 0", dut_view()); end
    checks++;
    if (bus.stall_count !== CW'(0)) begin errors++; $display("FAIL reset_cnt got %0d exp 0", bus.stall_count); end
  endtask

  task automatic test_imm_ext();
    instr_t i;
    i = plain_ins();
    i.regwrite = 1'b1; i.regdst = 1'b0; i.alu_src = 2'b01; i.alu_op = 3'b000;
    i.imm = 16'hFFFC; i.rt = 5'd5;
    apply(i, 1'b0, 1'b0);
    checks++;
    if (bus.stall !== 1'b0) begin errors++; $display("FAIL addi_stall got %b exp 0", bus.stall); end
    tick();
    checks++;
    if ({bus.ex_valid, bus.ex_regwrite, bus.ex_imm_ext, bus.ex_dst} !== {1'b1, 1'b1, 32'hFFFFFFFC, 5'd5}) begin
      errors++; $display("FAIL addi got v%b w%b imm %h dst %0d exp v1 w1 imm fffffffc dst 5",
                         bus.ex_valid, bus.ex_regwrite, bus.ex_imm_ext, bus.ex_dst);
    end
    i = plain_ins(); i.alu_src = 2'b10; i.imm = 16'h8001;
    apply(i, 1'b0, 1'b0); tick();
    checks++;
    if (bus.ex_imm_ext !== 32'h00008001) begin errors++; $display("FAIL ori_imm got %h exp 00008001", bus.ex_imm_ext); end
    i = plain_ins(); i.alu_src = 2'b00; i.imm = 16'h8000;
    apply(i, 1'b0, 1'b0); tick();
    checks++;
    if (bus.ex_imm_ext !== 32'hFFFF8000) begin errors++; $display("FAIL branch_imm got %h exp ffff8000", bus.ex_imm_ext); end
    i = plain_ins(); i.alu_src = 2'b11; i.imm = 16'h1234;
    apply(i, 1'b0, 1'b0); tick();
    checks++;
    if (bus.ex_imm_ext !== 32'h0) begin errors++; $display("FAIL rsvd_imm got %h exp 0", bus.ex_imm_ext); end
    i = plain_ins(); i.regdst = 1'b1; i.rd = 5'd9; i.rt = 5'd4;
    apply(i, 1'b0, 1'b0); tick();
    checks++;
    if (bus.ex_dst !== 5'd9) begin errors++; $display("FAIL rtype_dst got %0d exp 9", bus.ex_dst); end
    checks++;
    if (dut_view() !== model_view()) begin errors++; $display("FAIL rtype_all got %h exp %h", dut_view(), model_view()); end
  endtask

  task automatic test_load_use();
    instr_t lw, dep;
    int     c0;
    lw = plain_ins(); lw.memread = 1'b1; lw.rt = 5'd7;
    dep = plain_ins(); dep.rs = 5'd7; dep.rt = 5'd2;
    apply(lw, 1'b0, 1'b0); tick();
    c0 = m_cnt;
    apply(dep, 1'b0, 1'b0);
    checks++;
    if (bus.stall !== 1'b1) begin errors++; $display("FAIL lu_stall got %b exp 1", bus.stall); end
    tick();
    checks++;
    if (dut_view() !== ex_t'(0)) begin errors++; $display("FAIL lu_bubble got %h exp 0", dut_view()); end
    checks++;
    if (bus.stall_count !== CW'(c0 + 1)) begin errors++; $display("FAIL lu_cnt got %0d exp %0d", bus.stall_count, c0 + 1); end
    apply(dep, 1'b0, 1'b0);
    checks++;
    if (bus.stall !== 1'b0) begin errors++; $display("FAIL lu_release got %b exp 0", bus.stall); end
    tick();
    checks++;
    if (dut_view() !== model_view() || bus.ex_valid !== 1'b1) begin
      errors++; $display("FAIL lu_proceed got %h exp %h", dut_view(), model_view());
    end
  endtask

  task automatic test_zero_load();
    instr_t lw, dep;
    int     c0;
    c0 = m_cnt;
    lw = plain_ins(); lw.memread = 1'b1; lw.rt = 5'd0;
    dep = plain_ins(); dep.rs = 5'd0; dep.rt = 5'd0;
    apply(lw, 1'b0, 1'b0); tick();
    apply(dep, 1'b0, 1'b0);
    checks++;
    if (bus.stall !== 1'b0) begin errors++; $display("FAIL r0_stall got %b exp 0", bus.stall); end
    tick();
    checks++;
    if (bus.stall_count !== CW'(c0) || bus.ex_valid !== 1'b1) begin
      errors++; $display("FAIL r0_cnt got %0d v%b exp %0d v1", bus.stall_count, bus.ex_valid, c0);
    end
  endtask

  task automatic test_flush();
    instr_t lw, dep, sw;
    int     c0;
    lw = plain_ins(); lw.memread = 1'b1; lw.rt = 5'd7;
    dep = plain_ins(); dep.rt = 5'd7; dep.rs = 5'd1;
    apply(lw, 1'b0, 1'b0); tick();
    c0 = m_cnt;
    apply(dep, 1'b1, 1'b0);
    checks++;
    if (bus.stall !== 1'b1) begin errors++; $display("FAIL fl_stall got %b exp 1", bus.stall); end
    tick();
    checks++;
    if (dut_view() !== ex_t'(0) || bus.stall_count !== CW'(c0)) begin
      errors++; $display("FAIL fl_stall_bubble got %h cnt %0d exp 0 cnt %0d", dut_view(), bus.stall_count, c0);
    end
    sw = plain_ins(); sw.memwrite = 1'b1;
    apply(sw, 1'b1, 1'b0); tick();
    checks++;
    if ({bus.ex_memwrite, bus.ex_valid} !== 2'b00) begin
      errors++; $display("FAIL fl_sw got w%b v%b exp w0 v0", bus.ex_memwrite, bus.ex_valid);
    end
  endtask

  task automatic test_reset_mid_stall();
    instr_t lw, dep;
    lw = plain_ins(); lw.memread = 1'b1; lw.rt = 5'd7;
    dep = plain_ins(); dep.rs = 5'd7;
    apply(lw, 1'b0, 1'b0); tick();
    apply(dep, 1'b0, 1'b0);
    checks++;
    if (bus.stall !== 1'b1) begin errors++; $display("FAIL rms_pre got %b exp 1", bus.stall); end
    apply(dep, 1'b1, 1'b1);
    checks++;
    if (bus.stall !== 1'b0) begin errors++; $display("FAIL rms_stall got %b exp 0", bus.stall); end
    tick();
    checks++;
    if (dut_view() !== ex_t'(0) || bus.stall_count !== CW'(0)) begin
      errors++; $display("FAIL rms_clear got %h cnt %0d exp 0 cnt 0", dut_view(), bus.stall_count);
    end
  endtask

  task automatic test_saturation();
    instr_t lw;
    lw = plain_ins(); lw.memread = 1'b1; lw.rs = 5'd7; lw.rt = 5'd7;
    for (int n = 0; n < 2 * (CMAX + 3); n++) begin
      apply(lw, 1'b0, 1'b0); tick();
      checks++;
      if (bus.stall_count !== CW'(m_cnt)) begin
        errors++; $display("FAIL sat_step got %0d exp %0d", bus.stall_count, m_cnt);
      end
    end
    checks++;
    if (bus.stall_count !== CW'(CMAX)) begin errors++; $display("FAIL sat_hold got %0d exp %0d", bus.stall_count, CMAX); end
  endtask

  task automatic test_random();
    instr_t i;
    bit     hold;
    hold = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (!hold) begin
        i = rand_ins();
        i.rs = 5'($urandom_range(0, 3));
        i.rt = 5'($urandom_range(0, 3));
      end
      apply(i, ($urandom_range(0, 9) == 0), ($urandom_range(0, 49) == 0));
      checks++;
      if (bus.stall !== exp_stall) begin errors++; $display("FAIL rnd_stall n=%0d got %b exp %b", n, bus.stall, exp_stall); end
      hold = exp_stall && !cur_fl;
      tick();
      checks++;
      if (dut_view() !== model_view() || bus.stall_count !== CW'(m_cnt)) begin
        errors++; $display("FAIL rnd_ex n=%0d got %h cnt %0d exp %h cnt %0d",
                           n, dut_view(), bus.stall_count, model_view(), m_cnt);
      end
    end
  endtask

  initial begin
    m_ins = '0; m_valid = 1'b0; m_cnt = 0;
    test_reset();
    test_imm_ext();
    test_load_use();
    test_zero_load();
    test_flush();
    test_reset_mid_stall();
    test_saturation();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode-to-execute boundary of the 5-stage pipelined MIPS core.
- Registers the decode control bundle (RegDst, J, Beq, Bneq, MemRead, MemtoReg, MemWrite, RegWrite, Alu_src, Alu_op) together with operands, immediate and register specifiers into the EX stage.
- Performs immediate extension according to Alu_src.
- Detects load-use hazards and inserts bubbles, both for stalls and for external flushes.

Parameters:
- DATA_W, 32, datapath width.
- REG_AW, 5, register specifier width.
- CNT_W, 16, width of the saturating stall counter.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  reset, synchronous, active-high
- flush  in  1  branch/jump redirect; kill the instruction entering EX
- id_regdst, id_j, id_beq, id_bneq, id_memread, id_memtoreg, id_memwrite, id_regwrite  in  1 each  decode control bits
- id_alu_src  in  2  00 reg, 01 sign-extend, 10 zero-extend, 11 reserved
- id_alu_op  in  3  ALU operation class
- id_pc4  in  DATA_W  PC+4 of the ID instruction
- id_rs_data, id_rt_data  in  DATA_W  register file read data
- id_imm  in  16  instruction[15:0]
- id_rs, id_rt, id_rd  in  REG_AW  instruction fields
- stall  out  1  combinational; freeze PC and IF/ID this cycle
- ex_regdst, ex_j, ex_beq, ex_bneq, ex_memread, ex_memtoreg, ex_memwrite, ex_regwrite  out  1 each  registered control
- ex_alu_src  out  2  registered
- ex_alu_op  out  3  registered
- ex_pc4, ex_rs_data, ex_rt_data  out  DATA_W  registered
- ex_imm_ext  out  DATA_W  extended immediate
- ex_rs, ex_rt  out  REG_AW  for the forwarding unit
- ex_dst  out  REG_AW  write destination: id_rd if id_regdst=1, else id_rt
- ex_valid  out  1  1 = real instruction, 0 = bubble
- stall_count  out  CNT_W  number of stall cycles, saturating

Behaviour:
- All ex_* outputs and stall_count are registered and update only on the rising edge.
- Reset:
  - On reset=1 at an edge, every ex_* output and stall_count go to 0.
  - Reset has priority over everything else.
  - Reset asserted mid-stall or mid-flush still clears everything in that cycle.
- Hazard detection:
  - stall = ex_memread & ex_valid & (ex_rt != 0) & ((ex_rt == id_rs) | (ex_rt == id_rt)).
  - stall is purely combinational and is forced to 0 while reset=1.
- Update priority at each edge when reset=0:
  - flush=1: load a bubble. flush wins over stall.
  - Else stall=1: load a bubble. Upstream holds, so the same ID instruction is re-presented next cycle.
  - Else: capture all id_* inputs and set ex_valid=1.
- Bubble contents:
  - Every ex_* output is 0, including data fields and ex_dst, and ex_valid=0.
  - A bubble therefore never writes registers or memory and never branches.
- Immediate extension (registered into ex_imm_ext):
  - alu_src=01: sign-extend id_imm to DATA_W.
  - alu_src=10: zero-extend id_imm.
  - alu_src=00: sign-extend. Branch offsets need this even though the ALU operand is a register.
  - alu_src=11: zero.
- Any X on a control input whose opcode leaves that bit don't-care is captured as-is. Verification treats such bits as don't-care only when ex_valid=0, or when the bit is architecturally unused for that opcode.
- stall_count:
  - Increments by 1 on each edge where stall=1 and flush=0.
  - Holds at all-ones, no wrap.
  - A flush cycle does not count.
- Latency:
  - One cycle from id_* to ex_*.
  - A load-use hazard costs exactly one bubble. On the edge after the bubble, ex_memread=0, so stall deasserts and the held instruction proceeds.
- $zero rule: a load targeting r0 never stalls.

Test Plan:
- Reset, then id addi (regwrite=1, alu_src=01, alu_op=add, imm=16'hFFFC, rt=5) -> next cycle ex_valid=1, ex_regwrite=1, ex_imm_ext=32'hFFFFFFFC, ex_dst=5, stall=0.
- ori with imm=16'h8001, alu_src=10 -> ex_imm_ext=32'h00008001. R-type with regdst=1, rd=9, rt=4 -> ex_dst=9.
- Load-use: lw rt=7 captured, next ID has rs=7 -> stall=1 for exactly one cycle, then ex_valid=0 with all control 0, stall_count=1; on the following edge the dependent instruction is captured with ex_valid=1.
- lw with rt=0 followed by an instruction with rs=0 -> stall never asserts and stall_count stays 0.
- flush=1 during a load-use stall -> bubble loaded, stall_count unchanged. flush=1 on a normal sw -> ex_memwrite=0, ex_valid=0.
- reset pulsed while ex holds a valid lw and stall=1 -> next edge all outputs 0, stall deasserted. stall_count forced to all-ones minus 1, then 3 stall cycles -> holds at 16'hFFFF.
